trap_ctrl_n: RTL and testbench

Parametrised machine-mode trap controller for the single-issue core. It sits between the decode/execute stage, the CSR file and the PC mux.
- Arbitrates synchronous exceptions, NUM_EXT_IRQ external lines, the timer interrupt and the software interrupt.
- Sequences CSR updates (mstatus, mepc, mcause, mtval) and redirects the PC to a direct or vectored handler address.
- Adds MRET handling, per-line external enables/acknowledges and vectored mode.

---
 rtl/trap_ctrl_n_pkg.sv | 37 +++
 rtl/trap_ctrl_n_if.sv | 13 +
 rtl/trap_ctrl_n_prio_enc.sv | 41 ++++
 rtl/trap_ctrl_n.sv | 241 ++++++++++++++++++++++++
 tb/tb_trap_ctrl_n.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/trap_ctrl_n_pkg.sv
// Shared definitions for the machine-mode trap controller: CSR addresses,
// mcause codes, mstatus bit positions and FSM state encoding.
package trap_ctrl_n_pkg;

    localparam int CSR_ADDR_W = 12;

    typedef logic [CSR_ADDR_W-1:0] csr_addr_t;
    typedef logic [4:0]            cause_code_t;

    localparam csr_addr_t CSR_MSTATUS = 12'h300;
    localparam csr_addr_t CSR_MTVEC   = 12'h305;
    localparam csr_addr_t CSR_MEPC    = 12'h341;
    localparam csr_addr_t CSR_MCAUSE  = 12'h342;
    localparam csr_addr_t CSR_MTVAL   = 12'h343;

    localparam cause_code_t CAUSE_INST_ERR = 5'd2;
    localparam cause_code_t CAUSE_EBREAK   = 5'd3;
    localparam cause_code_t CAUSE_MEM_ERR  = 5'd5;
    localparam cause_code_t CAUSE_ECALL    = 5'd11;
    localparam cause_code_t CAUSE_IRQ_SW   = 5'd3;
    localparam cause_code_t CAUSE_IRQ_TMR  = 5'd7;
    localparam int          IRQ_EXT_BASE   = 16;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_WSTA = 4'd1;
    localparam logic [3:0] ST_WEPC = 4'd2;
    localparam logic [3:0] ST_WCAU = 4'd3;
    localparam logic [3:0] ST_WTVL = 4'd4;
    localparam logic [3:0] ST_JUMP = 4'd5;
    localparam logic [3:0] ST_MRST = 4'd6;
    localparam logic [3:0] ST_MRJP = 4'd7;
    localparam logic [3:0] ST_SWFI = 4'd8;

endpackage

// File: rtl/trap_ctrl_n_if.sv
// CSR access bus between the trap controller (master) and the CSR file (slave).
// Read data is combinational for the address presented in the same cycle.
interface trap_ctrl_n_if #(parameter int XLEN = 32);
    import trap_ctrl_n_pkg::*;

    logic [XLEN-1:0]       csr_rdata;
    logic [XLEN-1:0]       csr_wdata;
    logic                  csr_we;
    logic [CSR_ADDR_W-1:0] csr_addr;

    modport master (input csr_rdata, output csr_wdata, output csr_we, output csr_addr);
    modport slave  (output csr_rdata, input csr_wdata, input csr_we, input csr_addr);
endinterface

// File: rtl/trap_ctrl_n_prio_enc.sv
// Interrupt priority encoder: lowest-index external line first, then software,
// then timer. Purely combinational.
module trap_ctrl_n_prio_enc
    import trap_ctrl_n_pkg::*;
#(
    parameter int NUM_EXT_IRQ = 4
) (
    input  logic [NUM_EXT_IRQ-1:0] ext_pend,
    input  logic                   sw_pend,
    input  logic                   tmr_pend,
    output logic                   irq_any,
    output cause_code_t            irq_code,
    output logic [NUM_EXT_IRQ-1:0] ext_oh
);

    // Pick the winning interrupt; descending scan leaves the lowest index set.
    always_comb begin
        irq_any  = 1'b0;
        irq_code = 5'd0;
        ext_oh   = {NUM_EXT_IRQ{1'b0}};
        if (|ext_pend) begin
            irq_any = 1'b1;
            for (int i = NUM_EXT_IRQ - 1; i >= 0; i--) begin
                if (ext_pend[i]) begin
                    ext_oh    = {NUM_EXT_IRQ{1'b0}};
                    ext_oh[i] = 1'b1;
                    irq_code  = 5'(IRQ_EXT_BASE + i);
                end
            end
        end else if (sw_pend) begin
            irq_any  = 1'b1;
            irq_code = CAUSE_IRQ_SW;
        end else if (tmr_pend) begin
            irq_any  = 1'b1;
            irq_code = CAUSE_IRQ_TMR;
        end else begin
            irq_any  = 1'b0;
        end
    end

endmodule

// File: rtl/trap_ctrl_n.sv
// Machine-mode trap controller: arbitrates exceptions and interrupts, sequences
// the mstatus/mepc/mcause/mtval updates, handles MRET/WFI and redirects the PC.
module trap_ctrl_n
    import trap_ctrl_n_pkg::*;
#(
    parameter int NUM_EXT_IRQ = 4,
    parameter int VECTORED_EN = 1,
    parameter int XLEN        = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    trap_ctrl_n_if.master          csr,
    input  logic                   ecall_i,
    input  logic                   ebreak_i,
    input  logic                   inst_err_i,
    input  logic                   mem_err_i,
    input  logic                   mret_i,
    input  logic                   wfi_i,
    input  logic [NUM_EXT_IRQ-1:0] irq_ext_i,
    input  logic [NUM_EXT_IRQ-1:0] irq_ext_en_i,
    input  logic                   meie_i,
    input  logic                   mtie_i,
    input  logic                   msie_i,
    input  logic                   tcmp_irq_i,
    input  logic                   soft_irq_i,
    input  logic                   mstatus_mie_i,
    input  logic [XLEN-1:0]        pc_i,
    input  logic [XLEN-1:0]        inst_i,
    input  logic [XLEN-1:0]        mem_addr_i,
    input  logic [XLEN-1:0]        pc_n_i,
    output logic [XLEN-1:0]        pc_n_o,
    output logic                   trap_jump_o,
    output logic                   trap_busy_o,
    output logic [NUM_EXT_IRQ-1:0] irq_ack_o
);

    function automatic logic [XLEN-1:0] mstatus_enter(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r               = v;
        r[12:11]        = 2'b11;
        r[MSTATUS_MPIE] = v[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] mstatus_leave(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r               = v;
        r[MSTATUS_MIE]  = v[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

    logic [3:0]             state_r, state_n_s;
    cause_code_t            cause_r, cause_n_s, exc_code_s, irq_code_s;
    logic                   intr_r;
    logic [XLEN-1:0]        mtval_r, mtval_n_s, exc_tval_s, epc_r;
    logic [NUM_EXT_IRQ-1:0] ack_oh_r, ack_n_s, irq_oh_s, ext_pend_s;
    logic                   irq_any_s, irq_take_s, exc_any_s, latch_s, take_irq_s;
    logic [XLEN-1:0]        mcause_s, base_s, target_s;

    assign ext_pend_s = irq_ext_i & irq_ext_en_i & {NUM_EXT_IRQ{meie_i}};

    trap_ctrl_n_prio_enc #(.NUM_EXT_IRQ(NUM_EXT_IRQ)) u_prio (
        .ext_pend (ext_pend_s),
        .sw_pend  (soft_irq_i & msie_i),
        .tmr_pend (tcmp_irq_i & mtie_i),
        .irq_any  (irq_any_s),
        .irq_code (irq_code_s),
        .ext_oh   (irq_oh_s)
    );

    assign irq_take_s = mstatus_mie_i & irq_any_s;
    assign exc_any_s  = inst_err_i | ebreak_i | ecall_i | mem_err_i;

    // Exception cause and trap value in fixed priority order.
    always_comb begin
        exc_tval_s = {XLEN{1'b0}};
        if (inst_err_i) begin
            exc_code_s = CAUSE_INST_ERR;
            exc_tval_s = inst_i;
        end else if (ebreak_i) begin
            exc_code_s = CAUSE_EBREAK;
        end else if (ecall_i) begin
            exc_code_s = CAUSE_ECALL;
        end else if (mem_err_i) begin
            exc_code_s = CAUSE_MEM_ERR;
            exc_tval_s = mem_addr_i;
        end else begin
            exc_code_s = 5'd0;
        end
    end

    // Next-state logic; latch_s marks the single cycle the trap info is captured.
    always_comb begin
        state_n_s  = state_r;
        latch_s    = 1'b0;
        take_irq_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (exc_any_s) begin
                    state_n_s = ST_WSTA;
                    latch_s   = 1'b1;
                end else if (irq_take_s) begin
                    state_n_s  = ST_WSTA;
                    latch_s    = 1'b1;
                    take_irq_s = 1'b1;
                end else if (mret_i) begin
                    state_n_s = ST_MRST;
                end else if (wfi_i) begin
                    state_n_s = ST_SWFI;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_SWFI: begin
                if (exc_any_s) begin
                    state_n_s = ST_WSTA;
                    latch_s   = 1'b1;
                end else if (irq_take_s) begin
                    state_n_s  = ST_WSTA;
                    latch_s    = 1'b1;
                    take_irq_s = 1'b1;
                end else if (irq_any_s) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_SWFI;
                end
            end
            ST_WSTA: state_n_s = ST_WEPC;
            ST_WEPC: state_n_s = ST_WCAU;
            ST_WCAU: state_n_s = ST_WTVL;
            ST_WTVL: state_n_s = ST_JUMP;
            ST_MRST: state_n_s = ST_MRJP;
            default: state_n_s = ST_IDLE;
        endcase
    end

    assign cause_n_s = take_irq_s ? irq_code_s : exc_code_s;
    assign mtval_n_s = take_irq_s ? {XLEN{1'b0}} : exc_tval_s;
    assign ack_n_s   = take_irq_s ? irq_oh_s : {NUM_EXT_IRQ{1'b0}};

    // State register and latched trap information.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cause_r  <= 5'd0;
            intr_r   <= 1'b0;
            mtval_r  <= {XLEN{1'b0}};
            epc_r    <= {XLEN{1'b0}};
            ack_oh_r <= {NUM_EXT_IRQ{1'b0}};
        end else begin
            state_r <= state_n_s;
            if (latch_s) begin
                cause_r  <= cause_n_s;
                intr_r   <= take_irq_s;
                mtval_r  <= mtval_n_s;
                epc_r    <= pc_i;
                ack_oh_r <= ack_n_s;
            end
        end
    end

    always_comb begin
        mcause_s         = {XLEN{1'b0}};
        mcause_s[4:0]    = cause_r;
        mcause_s[XLEN-1] = intr_r;
    end

    assign base_s = {csr.csr_rdata[XLEN-1:2], 2'b00};

    // Vectored offset is only ever applied to interrupts.
    always_comb begin
        if ((VECTORED_EN != 0) && (csr.csr_rdata[1:0] == 2'b01) && intr_r) begin
            target_s = base_s + {{(XLEN-7){1'b0}}, cause_r, 2'b00};
        end else begin
            target_s = base_s;
        end
    end

    // CSR bus and PC redirect decoded from the current state.
    always_comb begin
        csr.csr_we    = 1'b0;
        csr.csr_addr  = 12'h000;
        csr.csr_wdata = {XLEN{1'b0}};
        trap_jump_o   = 1'b0;
        irq_ack_o     = {NUM_EXT_IRQ{1'b0}};
        pc_n_o        = pc_n_i;
        case (state_r)
            ST_WSTA: begin
                csr.csr_we    = 1'b1;
                csr.csr_addr  = CSR_MSTATUS;
                csr.csr_wdata = mstatus_enter(csr.csr_rdata);
            end
            ST_WEPC: begin
                csr.csr_we    = 1'b1;
                csr.csr_addr  = CSR_MEPC;
                csr.csr_wdata = epc_r;
            end
            ST_WCAU: begin
                csr.csr_we    = 1'b1;
                csr.csr_addr  = CSR_MCAUSE;
                csr.csr_wdata = mcause_s;
            end
            ST_WTVL: begin
                csr.csr_we    = 1'b1;
                csr.csr_addr  = CSR_MTVAL;
                csr.csr_wdata = mtval_r;
            end
            ST_JUMP: begin
                csr.csr_addr = CSR_MTVEC;
                trap_jump_o  = 1'b1;
                irq_ack_o    = ack_oh_r;
                pc_n_o       = target_s;
            end
            ST_MRST: begin
                csr.csr_we    = 1'b1;
                csr.csr_addr  = CSR_MSTATUS;
                csr.csr_wdata = mstatus_leave(csr.csr_rdata);
            end
            ST_MRJP: begin
                csr.csr_addr = CSR_MEPC;
                trap_jump_o  = 1'b1;
                pc_n_o       = {csr.csr_rdata[XLEN-1:1], 1'b0};
            end
            default: begin
                pc_n_o = pc_n_i;
            end
        endcase
    end

    // Stall whenever a sequence is running or is being started this cycle.
    always_comb begin
        if (state_r != ST_IDLE) begin
            trap_busy_o = 1'b1;
        end else begin
            trap_busy_o = exc_any_s | irq_take_s | mret_i | wfi_i;
        end
    end

endmodule

// File: tb/tb_trap_ctrl_n.sv
// Directed bench for trap_ctrl_n: trap entry, vectored interrupts, priority,
// MRET, WFI and mid-sequence reset, with hand-computed expectations.
module tb_trap_ctrl_n;
    import trap_ctrl_n_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ecall_i, ebreak_i, inst_err_i, mem_err_i, mret_i, wfi_i;
    logic [3:0]  irq_ext_i, irq_ext_en_i;
    logic        meie_i, mtie_i, msie_i, tcmp_irq_i, soft_irq_i, mstatus_mie_i;
    logic [31:0] pc_i, inst_i, mem_addr_i, pc_n_i, pc_n_o;
    logic        trap_jump_o, trap_busy_o;
    logic [3:0]  irq_ack_o;
    logic [31:0] mstatus_v, mepc_v, mtvec_v;
    int          n_chk = 0;
    int          n_fail = 0;

    trap_ctrl_n_if #(.XLEN(32)) csr_bus ();

    trap_ctrl_n #(.NUM_EXT_IRQ(4), .VECTORED_EN(1), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .csr(csr_bus.master),
        .ecall_i(ecall_i), .ebreak_i(ebreak_i), .inst_err_i(inst_err_i), .mem_err_i(mem_err_i),
        .mret_i(mret_i), .wfi_i(wfi_i), .irq_ext_i(irq_ext_i), .irq_ext_en_i(irq_ext_en_i),
        .meie_i(meie_i), .mtie_i(mtie_i), .msie_i(msie_i), .tcmp_irq_i(tcmp_irq_i),
        .soft_irq_i(soft_irq_i), .mstatus_mie_i(mstatus_mie_i), .pc_i(pc_i), .inst_i(inst_i),
        .mem_addr_i(mem_addr_i), .pc_n_i(pc_n_i), .pc_n_o(pc_n_o), .trap_jump_o(trap_jump_o),
        .trap_busy_o(trap_busy_o), .irq_ack_o(irq_ack_o)
    );

    always #5 clk = ~clk;

    // Minimal CSR file read port; contents are set directly by the stimulus.
    always_comb begin
        case (csr_bus.csr_addr)
            CSR_MSTATUS: csr_bus.csr_rdata = mstatus_v;
            CSR_MEPC:    csr_bus.csr_rdata = mepc_v;
            CSR_MTVEC:   csr_bus.csr_rdata = mtvec_v;
            default:     csr_bus.csr_rdata = 32'h0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_req();
        ecall_i = 1'b0; ebreak_i = 1'b0; inst_err_i = 1'b0; mem_err_i = 1'b0;
        mret_i = 1'b0; wfi_i = 1'b0; irq_ext_i = 4'b0000;
    endtask

    // Walk a full trap entry from the detect cycle through JUMP and back to IDLE.
    task automatic trap_seq(input string tag, input logic [31:0] e_mst, input logic [31:0] e_epc,
                            input logic [31:0] e_cause, input logic [31:0] e_tval,
                            input logic [31:0] e_pc, input logic [3:0] e_ack);
        chk({tag, ".busy"}, {31'd0, trap_busy_o}, 32'd1);
        step();
        drop_req();
        chk({tag, ".sta"}, {19'd0, csr_bus.csr_we, csr_bus.csr_addr}, {19'd0, 1'b1, CSR_MSTATUS});
        chk({tag, ".mst"}, csr_bus.csr_wdata, e_mst);
        step();
        chk({tag, ".epc"}, csr_bus.csr_wdata, e_epc);
        step();
        chk({tag, ".cau_a"}, {19'd0, csr_bus.csr_we, csr_bus.csr_addr}, {19'd0, 1'b1, CSR_MCAUSE});
        chk({tag, ".cause"}, csr_bus.csr_wdata, e_cause);
        step();
        chk({tag, ".tval"}, csr_bus.csr_wdata, e_tval);
        step();
        chk({tag, ".jump"}, {27'd0, trap_jump_o, irq_ack_o}, {27'd0, 1'b1, e_ack});
        chk({tag, ".pc"}, pc_n_o, e_pc);
        mstatus_mie_i = 1'b0;
        step();
        chk({tag, ".done"}, {27'd0, trap_jump_o, irq_ack_o}, 32'd0);
        chk({tag, ".pcseq"}, pc_n_o, pc_n_i);
    endtask

    initial begin
        rst_n = 1'b0;
        drop_req();
        irq_ext_en_i = 4'b1111; meie_i = 1'b1; mtie_i = 1'b1; msie_i = 1'b1;
        tcmp_irq_i = 1'b0; soft_irq_i = 1'b0; mstatus_mie_i = 1'b0;
        pc_i = 32'h100; inst_i = 32'h0000_ffff; mem_addr_i = 32'hdead_0000; pc_n_i = 32'h104;
        mstatus_v = 32'h8; mepc_v = 32'h0; mtvec_v = 32'h200;
        #1;
        chk("rst.outs", {22'd0, csr_bus.csr_we, trap_jump_o, irq_ack_o, csr_bus.csr_addr[3:0]}, 32'd0);
        chk("rst.wdata", csr_bus.csr_wdata, 32'd0);
        chk("rst.pc", pc_n_o, 32'h104);
        step(); step();
        rst_n = 1'b1;
        step();

        // Plain ecall, direct mode.
        ecall_i = 1'b1;
        #1;
        trap_seq("ecall", 32'h1880, 32'h100, 32'd11, 32'd0, 32'h200, 4'b0000);

        // External lines 1 and 2 pending: line 1 wins, vectored target.
        mtvec_v = 32'h201; mstatus_mie_i = 1'b1; irq_ext_i = 4'b0110;
        #1;
        trap_seq("ext", 32'h1880, 32'h100, 32'h8000_0011, 32'd0, 32'h244, 4'b0010);

        // Disabled line is not pending.
        mstatus_mie_i = 1'b1; irq_ext_en_i = 4'b1110; irq_ext_i = 4'b0001;
        #1;
        chk("ext_dis.busy", {31'd0, trap_busy_o}, 32'd0);
        irq_ext_i = 4'b0000; irq_ext_en_i = 4'b1111;

        // Exception beats a simultaneous timer interrupt; exceptions never vector.
        ecall_i = 1'b1; tcmp_irq_i = 1'b1;
        #1;
        trap_seq("exc_vs_tmr", 32'h1880, 32'h100, 32'd11, 32'd0, 32'h200, 4'b0000);
        chk("tmr_masked.busy", {31'd0, trap_busy_o}, 32'd0);

        // MRET restores MIE from MPIE, then returns to mepc with bit 0 cleared.
        mstatus_v = 32'h80; mepc_v = 32'h345; mret_i = 1'b1;
        #1;
        chk("mret.busy", {31'd0, trap_busy_o}, 32'd1);
        step();
        mret_i = 1'b0;
        chk("mret.sta", {19'd0, csr_bus.csr_we, csr_bus.csr_addr}, {19'd0, 1'b1, CSR_MSTATUS});
        chk("mret.mst", csr_bus.csr_wdata, 32'h88);
        step();
        chk("mret.jump", {31'd0, trap_jump_o}, 32'd1);
        chk("mret.pc", pc_n_o, 32'h344);
        mstatus_v = 32'h88; mstatus_mie_i = 1'b1;
        step();
        // Timer still pending now that MIE is back.
        trap_seq("tmr", 32'h1880, 32'h100, 32'h8000_0007, 32'd0, 32'h21c, 4'b0000);
        tcmp_irq_i = 1'b0;

        // Interrupt wins over a simultaneous MRET.
        mstatus_v = 32'h88; mstatus_mie_i = 1'b1; mret_i = 1'b1; irq_ext_i = 4'b1000;
        #1;
        trap_seq("irq_vs_mret", 32'h1880, 32'h100, 32'h8000_0013, 32'd0, 32'h24c, 4'b1000);

        // Instruction error outranks memory error; mtval carries the instruction.
        mstatus_v = 32'h8; inst_err_i = 1'b1; mem_err_i = 1'b1;
        #1;
        trap_seq("ierr", 32'h1880, 32'h100, 32'd2, 32'h0000_ffff, 32'h200, 4'b0000);
        mem_err_i = 1'b1;
        #1;
        trap_seq("merr", 32'h1880, 32'h100, 32'd5, 32'hdead_0000, 32'h200, 4'b0000);

        // WFI with MIE=0: a pending interrupt only wakes the core.
        wfi_i = 1'b1;
        #1;
        chk("wfi0.busy", {31'd0, trap_busy_o}, 32'd1);
        step();
        wfi_i = 1'b0;
        chk("wfi0.sleep", {30'd0, trap_busy_o, csr_bus.csr_we}, 32'd2);
        soft_irq_i = 1'b1;
        step();
        chk("wfi0.wake", {29'd0, trap_busy_o, csr_bus.csr_we, trap_jump_o}, 32'd0);
        chk("wfi0.pc", pc_n_o, 32'h104);
        soft_irq_i = 1'b0;

        // WFI with MIE=1: wake-up takes the software interrupt.
        mstatus_mie_i = 1'b1; wfi_i = 1'b1;
        step();
        wfi_i = 1'b0;
        chk("wfi1.sleep", {31'd0, trap_busy_o}, 32'd1);
        soft_irq_i = 1'b1;
        #1;
        trap_seq("wfi1", 32'h1880, 32'h100, 32'h8000_0003, 32'd0, 32'h20c, 4'b0000);
        soft_irq_i = 1'b0;

        // Reset during WCAU: outputs clear at once, no trailing writes.
        ecall_i = 1'b1;
        step();
        ecall_i = 1'b0;
        step(); step();
        chk("abort.wcau", {19'd0, csr_bus.csr_we, csr_bus.csr_addr}, {19'd0, 1'b1, CSR_MCAUSE});
        rst_n = 1'b0;
        #1;
        chk("abort.outs", {20'd0, csr_bus.csr_we, trap_jump_o, trap_busy_o, irq_ack_o, csr_bus.csr_addr[4:0]}, 32'd0);
        chk("abort.pc", pc_n_o, 32'h104);
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("abort.idle", {30'd0, csr_bus.csr_we, trap_jump_o}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
